// File: rtl/tiny16_mem_arb.sv
// tiny16_mem_arb
//   Arbiter and sequencer for the tiny16 single-port, synchronous-read RAM.
//   Three requesters (boot loader, CPU data, CPU fetch) are serialised onto
//   the RAM port. Each access takes four cycles: IDLE (arbitrate) -> MEM
//   (RAM enabled) -> WAIT (RAM data valid, captured) -> ACK (one-cycle ack).
//   All outputs are registered.
//
// Parameters
//   AW : word-address width
//   DW : data width
//
// Ports
//   CLK, RST                  clock, asynchronous active-high reset
//   ld_req/we/addr/wdata      loader request, ld_ack completion
//   d_req/we/addr/wdata       CPU data request, d_ack completion
//   f_req/f_addr              CPU fetch read request, f_ack completion
//   rdata                     read data shared by all requesters
//   owner                     0 none, 1 loader, 2 data, 3 fetch
//   busy                      access in progress (MEM/WAIT/ACK)
//   mem_en/we/addr/wdata      RAM port, mem_rdata RAM read data
//
// Configuration
//   TINY16_ARB_RR_EN : round-robin between data and fetch when defined,
//                      otherwise fixed priority loader > data > fetch.

module tiny16_mem_arb #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] rdata,
  output logic [1:0]    owner,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_WAIT, S_ACK} state_t;

  state_t        r_state, w_state_nxt;

  logic          r_mem_en,    w_mem_en_nxt;
  logic          r_mem_we,    w_mem_we_nxt;
  logic [AW-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [DW-1:0] r_rdata,     w_rdata_nxt;
  logic [1:0]    r_owner,     w_owner_nxt;
  logic          r_busy,      w_busy_nxt;
  logic          r_ld_ack,    w_ld_ack_nxt;
  logic          r_d_ack,     w_d_ack_nxt;
  logic          r_f_ack,     w_f_ack_nxt;
  logic          w_pick_f;

`ifdef TINY16_ARB_RR_EN
  // 0 = data goes next on a data/fetch tie, 1 = fetch goes next
  logic          r_rr_fetch, w_rr_fetch_nxt;

  assign w_pick_f = f_req && (!d_req || r_rr_fetch);
`else
  assign w_pick_f = f_req && !d_req;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_rdata_nxt     = r_rdata;
    w_owner_nxt     = r_owner;
    w_ld_ack_nxt    = 1'b0;
    w_d_ack_nxt     = 1'b0;
    w_f_ack_nxt     = 1'b0;
`ifdef TINY16_ARB_RR_EN
    w_rr_fetch_nxt  = r_rr_fetch;
`endif
    case (r_state)
      S_IDLE: begin
        if (ld_req) begin
          w_mem_we_nxt    = ld_we;
          w_mem_addr_nxt  = ld_addr;
          w_mem_wdata_nxt = ld_wdata;
          w_owner_nxt     = 2'd1;
          w_mem_en_nxt    = 1'b1;
          w_state_nxt     = S_MEM;
        end else if (d_req || f_req) begin
          if (w_pick_f) begin
            // fetch never writes; write data register is left untouched
            w_mem_we_nxt   = 1'b0;
            w_mem_addr_nxt = f_addr;
            w_owner_nxt    = 2'd3;
          end else begin
            w_mem_we_nxt    = d_we;
            w_mem_addr_nxt  = d_addr;
            w_mem_wdata_nxt = d_wdata;
            w_owner_nxt     = 2'd2;
          end
`ifdef TINY16_ARB_RR_EN
          // pointer moves to the port that did not win, even when uncontended
          w_rr_fetch_nxt = !w_pick_f;
`endif
          w_mem_en_nxt = 1'b1;
          w_state_nxt  = S_MEM;
        end
      end
      S_MEM:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!r_mem_we) w_rdata_nxt = mem_rdata;
        case (r_owner)
          2'd1:    w_ld_ack_nxt = 1'b1;
          2'd2:    w_d_ack_nxt  = 1'b1;
          2'd3:    w_f_ack_nxt  = 1'b1;
          default: ;
        endcase
        w_state_nxt = S_ACK;
      end
      S_ACK: begin
        w_owner_nxt = 2'd0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_owner     <= '0;
      r_busy      <= 1'b0;
      r_ld_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_f_ack     <= 1'b0;
`ifdef TINY16_ARB_RR_EN
      r_rr_fetch  <= 1'b0;
`endif
    end else begin
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_owner     <= w_owner_nxt;
      r_busy      <= w_busy_nxt;
      r_ld_ack    <= w_ld_ack_nxt;
      r_d_ack     <= w_d_ack_nxt;
      r_f_ack     <= w_f_ack_nxt;
`ifdef TINY16_ARB_RR_EN
      r_rr_fetch  <= w_rr_fetch_nxt;
`endif
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = r_rdata;
  assign owner     = r_owner;
  assign busy      = r_busy;
  assign ld_ack    = r_ld_ack;
  assign d_ack     = r_d_ack;
  assign f_ack     = r_f_ack;

endmodule

// File: tb/tb_tiny16_mem_arb.sv
// Testbench for tiny16_mem_arb: reset checks, a table of single-access
// vectors, contention and mid-access reset sequences, then randomized
// traffic from three requester agents against a transaction-level model.
// Requester index: 0 loader, 1 data, 2 fetch (owner code = index + 1).

module tb_tiny16_mem_arb;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        a_req  [3];
  logic        a_we   [3];
  logic [7:0]  a_addr [3];
  logic [15:0] a_wd   [3];
  logic        ld_ack, d_ack, f_ack;
  logic [15:0] rdata;
  logic [1:0]  owner;
  logic        busy, mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] ram [256];
  int          init_mode = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 CLK = ~CLK;

  tiny16_mem_arb #(.AW(8), .DW(16)) dut (
    .CLK(CLK), .RST(RST),
    .ld_req(a_req[0]), .ld_we(a_we[0]), .ld_addr(a_addr[0]), .ld_wdata(a_wd[0]), .ld_ack(ld_ack),
    .d_req(a_req[1]), .d_we(a_we[1]), .d_addr(a_addr[1]), .d_wdata(a_wd[1]), .d_ack(d_ack),
    .f_req(a_req[2]), .f_addr(a_addr[2]), .f_ack(f_ack),
    .rdata(rdata), .owner(owner), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [15:0] init_word(input int mode, input int i);
    if (mode == 1) return (i == 16) ? 16'h1234 : {8'hA5, 8'(i)};
    return 16'(i * 257) ^ 16'h3C5A;
  endfunction

  // synchronous-read RAM macro stand-in
  always @(posedge CLK) begin
    if (init_mode != 0) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(init_mode, i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 3; i++) begin
      a_req[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_wd[i] = '0;
    end
  endtask

  typedef struct {
    logic [2:0]  req;      // {f, d, ld}
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [15:0] ld_wd;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [15:0] d_wd;
    logic [7:0]  f_addr;
    logic [1:0]  exp_owner;
    logic [7:0]  exp_addr;
    logic        exp_we;
    logic [15:0] exp_wd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  // one access from IDLE; called on a falling edge with the arbiter idle
  task automatic run_vec(input vec_t v, input int n);
    logic [2:0] ea;
    ea = 3'b000;
    ea[v.exp_owner - 2'd1] = 1'b1;
    a_req[0] = v.req[0]; a_we[0] = v.ld_we; a_addr[0] = v.ld_addr; a_wd[0] = v.ld_wd;
    a_req[1] = v.req[1]; a_we[1] = v.d_we;  a_addr[1] = v.d_addr;  a_wd[1] = v.d_wd;
    a_req[2] = v.req[2]; a_we[2] = 1'b0;    a_addr[2] = v.f_addr;  a_wd[2] = '0;
    @(negedge CLK);
    chk($sformatf("vec%0d mem busy", n), 32'(busy), 32'(1));
    chk($sformatf("vec%0d mem owner", n), 32'(owner), 32'(v.exp_owner));
    chk($sformatf("vec%0d mem_en", n), 32'(mem_en), 32'(1));
    chk($sformatf("vec%0d mem_addr", n), 32'(mem_addr), 32'(v.exp_addr));
    chk($sformatf("vec%0d mem_we", n), 32'(mem_we), 32'(v.exp_we));
    if (v.exp_we) chk($sformatf("vec%0d mem_wdata", n), 32'(mem_wdata), 32'(v.exp_wd));
    @(negedge CLK);
    chk($sformatf("vec%0d wait mem_en", n), 32'(mem_en), 32'(0));
    chk($sformatf("vec%0d wait acks", n), 32'({f_ack, d_ack, ld_ack}), 32'(0));
    chk($sformatf("vec%0d wait owner", n), 32'(owner), 32'(v.exp_owner));
    @(negedge CLK);
    chk($sformatf("vec%0d ack", n), 32'({f_ack, d_ack, ld_ack}), 32'(ea));
    chk($sformatf("vec%0d rdata", n), 32'(rdata), 32'(v.exp_rd));
    clear_reqs();
    @(negedge CLK);
    chk($sformatf("vec%0d idle busy", n), 32'(busy), 32'(0));
    chk($sformatf("vec%0d idle owner", n), 32'(owner), 32'(0));
    chk($sformatf("vec%0d idle acks", n), 32'({f_ack, d_ack, ld_ack}), 32'(0));
    chk($sformatf("vec%0d idle rdata", n), 32'(rdata), 32'(v.exp_rd));
  endtask

  task automatic new_req(input int i);
    a_req[i]  = 1'b1;
    a_we[i]   = (i == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    a_addr[i] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
    a_wd[i]   = 16'($urandom);
  endtask

  // transaction-level reference state for the random phase
  logic [15:0] shadow [256];
  int          m_t, m_w;
  logic        m_d_next, m_we;
  logic [7:0]  m_addr;
  logic [15:0] m_wd, m_rd, m_exp_rd;

  initial begin
    logic [1:0] exp_ord [4];
    logic       found, ackv;

    // vector table: {f,d,ld}, ld we/addr/wd, d we/addr/wd, f addr, owner, addr, we, wd, rdata
    vecs[0] = '{3'b100, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 8'h10, 2'd3, 8'h10, 1'b0, 16'h0000, 16'h1234};
    vecs[1] = '{3'b010, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h20, 16'hBEEF, 8'h00, 2'd2, 8'h20, 1'b1, 16'hBEEF, 16'h1234};
    vecs[2] = '{3'b010, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h20, 16'h0000, 8'h00, 2'd2, 8'h20, 1'b0, 16'h0000, 16'hBEEF};
    vecs[3] = '{3'b001, 1'b1, 8'h30, 16'hCAFE, 1'b0, 8'h00, 16'h0000, 8'h00, 2'd1, 8'h30, 1'b1, 16'hCAFE, 16'hBEEF};
    vecs[4] = '{3'b001, 1'b0, 8'h30, 16'h0000, 1'b0, 8'h00, 16'h0000, 8'h00, 2'd1, 8'h30, 1'b0, 16'h0000, 16'hCAFE};
    vecs[5] = '{3'b111, 1'b0, 8'h10, 16'h0000, 1'b0, 8'h20, 16'h0000, 8'hFF, 2'd1, 8'h10, 1'b0, 16'h0000, 16'h1234};
`ifdef TINY16_ARB_RR_EN
    // pointer points at fetch after two data wins
    vecs[6] = '{3'b110, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h20, 16'h0000, 8'hFF, 2'd3, 8'hFF, 1'b0, 16'h0000, 16'hA5FF};
    exp_ord = '{2'd2, 2'd3, 2'd2, 2'd3};
`else
    vecs[6] = '{3'b110, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h20, 16'h0000, 8'hFF, 2'd2, 8'h20, 1'b0, 16'h0000, 16'hBEEF};
    exp_ord = '{2'd2, 2'd2, 2'd2, 2'd2};
`endif
    vecs[7] = '{3'b100, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 8'h00, 2'd3, 8'h00, 1'b0, 16'h0000, 16'hA500};
    vecs[8] = '{3'b010, 1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 16'h5A5A, 8'h00, 2'd2, 8'hFF, 1'b1, 16'h5A5A, 16'hA500};
    vecs[9] = '{3'b100, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 8'hFF, 2'd3, 8'hFF, 1'b0, 16'h0000, 16'h5A5A};

    // reset held with every request high
    clear_reqs();
    a_req[0] = 1'b1; a_req[1] = 1'b1; a_req[2] = 1'b1;
    RST = 1'b1;
    init_mode = 1;
    repeat (4) begin
      @(negedge CLK);
      chk("rst acks", 32'({f_ack, d_ack, ld_ack}), 32'(0));
      chk("rst mem_en", 32'(mem_en), 32'(0));
      chk("rst busy", 32'(busy), 32'(0));
      chk("rst owner", 32'(owner), 32'(0));
      chk("rst rdata", 32'(rdata), 32'(0));
    end
    init_mode = 0;
    clear_reqs();
    RST = 1'b0;

    for (int n = 0; n < 10; n++) run_vec(vecs[n], n);

    // contention: data and fetch held high for four accesses
    a_req[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = 8'h20;
    a_req[2] = 1'b1; a_addr[2] = 8'h10;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        @(negedge CLK);
        if (d_ack || f_ack) begin
          found = 1'b1;
          chk($sformatf("grant order %0d", k), 32'(d_ack ? 2'd2 : 2'd3), 32'(exp_ord[k]));
        end
      end
      if (!found) chk($sformatf("grant timeout %0d", k), 32'(0), 32'(1));
    end
    clear_reqs();
    @(negedge CLK);

    // reset in MEM (p=1) and in WAIT (p=2): abandon, then reissue
    for (int p = 1; p <= 2; p++) begin
      a_req[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = 8'h20;
      repeat (p) @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      chk($sformatf("midrst%0d busy", p), 32'(busy), 32'(0));
      chk($sformatf("midrst%0d owner", p), 32'(owner), 32'(0));
      chk($sformatf("midrst%0d mem_en", p), 32'(mem_en), 32'(0));
      clear_reqs();
      @(negedge CLK);
      RST = 1'b0;
      repeat (3) begin
        @(negedge CLK);
        chk($sformatf("midrst%0d no ack", p), 32'(d_ack), 32'(0));
        chk($sformatf("midrst%0d idle", p), 32'(busy), 32'(0));
      end
      a_req[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = 8'h20;
      for (int c = 1; c <= 3; c++) begin
        @(negedge CLK);
        chk($sformatf("reissue%0d ack c%0d", p, c), 32'(d_ack), 32'(c == 3));
      end
      chk($sformatf("reissue%0d rdata", p), 32'(rdata), 32'(16'hBEEF));
      clear_reqs();
      @(negedge CLK);
    end

    // randomized traffic against the transaction model
    RST = 1'b1;
    init_mode = 2;
    clear_reqs();
    @(negedge CLK);
    RST = 1'b0;
    init_mode = 0;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(2, i);
    m_t = -1; m_w = 0; m_d_next = 1'b1; m_we = 1'b0; m_addr = '0; m_wd = '0; m_rd = '0;
    m_exp_rd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      // the requests visible now are the ones the last rising edge sampled
      if (m_t < 0) begin
        if (a_req[0] || a_req[1] || a_req[2]) begin
          if (a_req[0]) m_w = 0;
`ifdef TINY16_ARB_RR_EN
          else if (a_req[1] && a_req[2]) m_w = m_d_next ? 1 : 2;
`else
          else if (a_req[1] && a_req[2]) m_w = 1;
`endif
          else m_w = a_req[1] ? 1 : 2;
          if (m_w != 0) m_d_next = (m_w == 2);
          m_t = 0;
          m_we = a_we[m_w]; m_addr = a_addr[m_w]; m_wd = a_wd[m_w];
          if (m_we) shadow[m_addr] = m_wd;
          else      m_rd = shadow[m_addr];
        end
      end else begin
        m_t++;
        if (m_t == 3) m_t = -1;
      end
      if (m_t == 2 && !m_we) m_exp_rd = m_rd;

      chk("rnd busy", 32'(busy), 32'(m_t >= 0));
      chk("rnd owner", 32'(owner), (m_t >= 0) ? 32'(m_w + 1) : 32'(0));
      chk("rnd mem_en", 32'(mem_en), 32'(m_t == 0));
      chk("rnd acks", 32'({f_ack, d_ack, ld_ack}), (m_t == 2) ? (32'(1) << m_w) : 32'(0));
      chk("rnd rdata", 32'(rdata), 32'(m_exp_rd));
      if (m_t == 0) begin
        chk("rnd mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("rnd mem_we", 32'(mem_we), 32'(m_we));
        if (m_we) chk("rnd mem_wdata", 32'(mem_wdata), 32'(m_wd));
      end

      for (int i = 0; i < 3; i++) begin
        ackv = (i == 0) ? ld_ack : ((i == 1) ? d_ack : f_ack);
        if (a_req[i]) begin
          if (ackv) begin
            if ($urandom_range(0, 1) != 0) new_req(i);
            else a_req[i] = 1'b0;
          end
        end else if ($urandom_range(0, (i == 0) ? 7 : 2) == 0) begin
          new_req(i);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
